// File: rtl/reg_file_mp.sv
// Parametrised multi-port GPR file: NUM_RD combinational reads, NUM_WR clocked writes,
// optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    clr_state_t        state;
    clr_state_t        state_next;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              user_wr_ok;
    logic [NUM_WR-1:0] wr_live;

    assign user_wr_ok = (state == IDLE);

    // A write is live only outside the sweep and, with ZERO_R0, not aimed at entry 0.
    always_comb begin
        wr_live = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_live[j] = user_wr_ok && wr_en[j] &&
                         !(ZERO_R0 && (wr_addr[j*ADDR_W +: ADDR_W] == '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                clr_busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                clr_done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Index is held at zero outside the sweep so every sweep starts at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (state == SWEEP && idx != LAST_IDX) begin
            idx <= idx + ADDR_W'(1);
        end else begin
            idx <= '0;
        end
    end

    // Later ports overwrite earlier ones in loop order, so the highest index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == SWEEP) begin
            mem[idx] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_live[j]) begin
                    mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
            if (BYPASS) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_live[j] &&
                        (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])) begin
                        rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                    end
                end
            end
            if (ZERO_R0 && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp; a second instance with BYPASS=0
// shares all inputs so bypass and non-bypass behaviour can be compared side by side.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [63:0] rd_data_nb;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        clr_req = 1'b0;
    logic        clr_busy, clr_done;
    logic        clr_busy_nb, clr_done_nb;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    reg_file_mp #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic en, input logic [4:0] addr,
                                 input logic [31:0] data);
        wr_en[port]              = en;
        wr_addr[port*5 +: 5]     = addr;
        wr_data[port*32 +: 32]   = data;
    endtask

    task automatic setRead(input int port, input logic [4:0] addr);
        rd_addr[port*5 +: 5] = addr;
    endtask

    function automatic logic [31:0] rdPort(input int port);
        return rd_data[port*32 +: 32];
    endfunction

    function automatic logic [31:0] rdPortNb(input int port);
        return rd_data_nb[port*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  count;
        bit  found;

        // Reset state
        setRead(0, 5'd5);
        setRead(1, 5'd31);
        #2;
        checkOutput("reset_rd0", rdPort(0), 32'h0);
        checkOutput("reset_rd1", rdPort(1), 32'h0);
        checkOutput("reset_busy", {31'b0, clr_busy}, 32'h0);
        checkOutput("reset_done", {31'b0, clr_done}, 32'h0);
        #10 rst_n = 1'b1;
        tick();

        // Write r5 via port 0, read back via port 1
        applyStimulus(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        setRead(1, 5'd5);
        #1;
        checkOutput("wr_r5_rd_p1", rdPort(1), 32'hDEADBEEF);

        // Same-cycle bypass from port 1 into read port 0
        applyStimulus(1, 1'b1, 5'd7, 32'h12345678);
        setRead(0, 5'd7);
        #1;
        checkOutput("bypass_r7", rdPort(0), 32'h12345678);
        checkOutput("nobypass_r7", rdPortNb(0), 32'h0);
        tick();
        applyStimulus(1, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("nobypass_r7_after", rdPortNb(0), 32'h12345678);

        // Collision on r3: port 1 wins both in bypass and in the array
        applyStimulus(0, 1'b1, 5'd3, 32'h1111);
        applyStimulus(1, 1'b1, 5'd3, 32'h2222);
        setRead(0, 5'd3);
        #1;
        checkOutput("collide_bypass_r3", rdPort(0), 32'h2222);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("collide_r3", rdPort(0), 32'h2222);
        checkOutput("collide_r3_nb", rdPortNb(0), 32'h2222);

        // r0 stays zero
        applyStimulus(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        applyStimulus(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        setRead(0, 5'd0);
        #1;
        checkOutput("r0_bypass", rdPort(0), 32'h0);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("r0_after", rdPort(0), 32'h0);

        // Fill r1..r31, then sweep
        for (int a = 1; a < 32; a++) begin
            applyStimulus(0, 1'b1, 5'(a), 32'hA5A5A5A5);
            tick();
        end
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        setRead(0, 5'd1);
        setRead(1, 5'd31);
        #1;
        checkOutput("fill_r1", rdPort(0), 32'hA5A5A5A5);
        checkOutput("fill_r31", rdPort(1), 32'hA5A5A5A5);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        count = 0;
        for (int i = 0; i < 40 && clr_busy; i++) begin
            count++;
            if (clr_done) begin
                checkOutput("done_during_busy", {31'b0, clr_done}, 32'h0);
            end
            if (count == 5) begin
                applyStimulus(1, 1'b1, 5'd20, 32'h77);
                setRead(0, 5'd20);
                #1;
                checkOutput("sweep_no_bypass", rdPort(0), 32'hA5A5A5A5);
            end
            if (count == 6) begin
                applyStimulus(1, 1'b0, 5'd0, 32'h0);
                #1;
                checkOutput("sweep_wr_dropped", rdPort(0), 32'hA5A5A5A5);
            end
            tick();
        end
        checkOutput("busy_cycles", count, 32);
        checkOutput("done_pulse", {31'b0, clr_done}, 32'h1);
        checkOutput("busy_after", {31'b0, clr_busy}, 32'h0);
        tick();
        checkOutput("done_one_cycle", {31'b0, clr_done}, 32'h0);
        for (int a = 0; a < 32; a++) begin
            setRead(0, 5'(a));
            setRead(1, 5'(31 - a));
            #1;
            checkOutput($sformatf("cleared_p0_r%0d", a), rdPort(0), 32'h0);
            checkOutput($sformatf("cleared_p1_r%0d", 31 - a), rdPort(1), 32'h0);
        end

        // Reset in the middle of a sweep
        applyStimulus(0, 1'b1, 5'd25, 32'h25);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        setRead(0, 5'd25);
        #1;
        checkOutput("pre_reset_r25", rdPort(0), 32'h25);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checkOutput("sweep2_busy", {31'b0, clr_busy}, 32'h1);
        count = 1;
        while (count < 11) begin
            tick();
            count++;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", {31'b0, clr_busy}, 32'h0);
        checkOutput("midreset_done", {31'b0, clr_done}, 32'h0);
        checkOutput("midreset_r25", rdPort(0), 32'h0);
        tick();
        checkOutput("midreset_done_hold", {31'b0, clr_done}, 32'h0);
        #3 rst_n = 1'b1;
        tick();
        checkOutput("postreset_done", {31'b0, clr_done}, 32'h0);
        checkOutput("postreset_busy", {31'b0, clr_busy}, 32'h0);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checkOutput("resweep_busy", {31'b0, clr_busy}, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (clr_done) found = 1'b1;
        end
        checkOutput("resweep_done", {31'b0, found}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
